rvfi_commit_serializer: RTL and testbench

RVFI_COMMIT_SERIALIZER -- requirements
Module: rvfi_commit_serializer

---
 rtl/ariane_pkg.sv | 12 +
 rtl/config_pkg.sv | 15 +
 rtl/rvfi_commit_serializer.sv | 188 ++++++++++++++++++
 tb/tb_rvfi_commit_serializer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// -----------------------------------------------------------------------------
// ariane_pkg (trimmed slice)
// Shared constants for the RVFI commit serializer:
//   RVFI_SER_DEPTH_DEFAULT - default serializer buffer depth
//   RVFI_ORDER_WIDTH       - width of the retirement order counter
// -----------------------------------------------------------------------------
package ariane_pkg;

    localparam int unsigned RVFI_SER_DEPTH_DEFAULT = 8;
    localparam int unsigned RVFI_ORDER_WIDTH       = 64;

endpackage

// File: rtl/config_pkg.sv
// -----------------------------------------------------------------------------
// config_pkg (trimmed slice)
// Core configuration record. Only the field consumed by the RVFI commit
// serializer is carried here. The default configuration uses a dual-commit
// core so the serializer elaborates with its defaults.
// -----------------------------------------------------------------------------
package config_pkg;

    typedef struct packed {
        int unsigned NrCommitPorts;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 32'd2};

endpackage

// File: rtl/rvfi_commit_serializer.sv
// -----------------------------------------------------------------------------
// rvfi_commit_serializer
// Collects up to NrCommitPorts retired RVFI records per cycle into a ring
// buffer and presents them one at a time, tagged with a 64-bit retirement
// order. Records that do not fit are dropped; the order counter still
// advances for them, so drops show up as gaps in trace_order_o.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   rvfi_i            retired records, one per commit port, qualified by .valid
//   clear_i           synchronous buffer clear (tracer restart)
//   trace_o           head record (0 when empty)
//   trace_order_o     retirement order of the head record (0 when empty)
//   trace_valid_o     head record valid
//   trace_ready_i     consumer accepts the head record
//   overflow_o        sticky: at least one record dropped
//   drop_cnt_o        saturating dropped-record count
//                     (only with RVFI_SERIALIZER_DROP_CNT_EN defined)
// -----------------------------------------------------------------------------
module rvfi_commit_serializer
    import ariane_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg      = config_pkg::cva6_cfg_empty,
    parameter type                   rvfi_instr_t = logic,
    parameter int unsigned           Depth        = RVFI_SER_DEPTH_DEFAULT
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  rvfi_instr_t [CVA6Cfg.NrCommitPorts-1:0]       rvfi_i,
    input  logic                                          clear_i,
    output rvfi_instr_t                                   trace_o,
    output logic [RVFI_ORDER_WIDTH-1:0]                   trace_order_o,
    output logic                                          trace_valid_o,
    input  logic                                          trace_ready_i,
    output logic                                          overflow_o
`ifdef RVFI_SERIALIZER_DROP_CNT_EN
    ,
    output logic [31:0]                                   drop_cnt_o
`endif
);

    localparam int unsigned NrPorts = CVA6Cfg.NrCommitPorts;
    localparam int unsigned PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW    = $clog2(Depth + 1);

    typedef logic [RVFI_ORDER_WIDTH-1:0] order_t;

    if (((Depth & (Depth - 1)) != 0) || (Depth < 2 * NrPorts)) begin : g_bad_depth
        $error("Depth must be a power of two and at least 2*NrCommitPorts");
    end

    // Per-port valid flag. With the degenerate default record type the
    // single bit is itself the valid flag.
    logic [NrPorts-1:0] in_valid;
    for (genvar p = 0; p < NrPorts; p++) begin : g_valid
        if ($bits(rvfi_instr_t) == 1) begin : g_bit
            assign in_valid[p] = rvfi_i[p];
        end else begin : g_field
            assign in_valid[p] = rvfi_i[p].valid;
        end
    end

    // Entry storage: not reset, qualified by occupancy.
    rvfi_instr_t mem_q       [Depth];
    order_t      order_mem_q [Depth];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    order_t          order_q, order_d;
    logic            overflow_q, overflow_d;

    logic   [NrPorts-1:0]           wr_en;
    logic   [NrPorts-1:0][PtrW-1:0] wr_idx;
    order_t [NrPorts-1:0]           wr_order;
    logic                           pop;
    int unsigned                    n_push, n_drop, n_valid, free_slots;

    always_comb begin
        n_push     = 0;
        n_drop     = 0;
        n_valid    = 0;
        wr_en      = '0;
        wr_idx     = '0;
        wr_order   = '0;
        // Free space is taken from start-of-cycle occupancy, so a
        // concurrent pop never makes room for a push.
        free_slots = Depth - 32'(count_q);
        for (int unsigned p = 0; p < NrPorts; p++) begin
            if (in_valid[p]) begin
                wr_order[p] = order_q + order_t'(n_valid);
                // Records arriving during a clear are discarded silently:
                // they are neither stored nor counted as drops.
                if (!clear_i) begin
                    if (n_push < free_slots) begin
                        wr_en[p]  = 1'b1;
                        wr_idx[p] = wr_ptr_q + PtrW'(n_push);
                        n_push++;
                    end else begin
                        n_drop++;
                    end
                end
                n_valid++;
            end
        end

        pop     = (count_q != '0) && trace_ready_i;
        order_d = order_q + order_t'(n_valid);

        if (clear_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            wr_ptr_d   = wr_ptr_q + PtrW'(n_push);
            rd_ptr_d   = rd_ptr_q + PtrW'(pop);
            count_d    = count_q + CntW'(n_push) - CntW'(pop);
            overflow_d = overflow_q | (n_drop != 0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            order_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            order_q    <= order_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned p = 0; p < NrPorts; p++) begin
            if (wr_en[p]) begin
                mem_q[wr_idx[p]]       <= rvfi_i[p];
                order_mem_q[wr_idx[p]] <= wr_order[p];
            end
        end
    end

    // Outputs come only from registered state: no commit-to-trace bypass.
    // Forced to zero while empty, which also covers reset.
    assign trace_valid_o = (count_q != '0);
    assign overflow_o    = overflow_q;

    always_comb begin
        trace_o       = '0;
        trace_order_o = '0;
        if (trace_valid_o) begin
            trace_o       = mem_q[rd_ptr_q];
            trace_order_o = order_mem_q[rd_ptr_q];
        end
    end

`ifdef RVFI_SERIALIZER_DROP_CNT_EN
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic [32:0] drop_sum;

    always_comb begin
        drop_sum = {1'b0, drop_cnt_q} + 33'(n_drop);
        if (clear_i) begin
            drop_cnt_d = '0;
        end else if (drop_sum[32]) begin
            drop_cnt_d = '1;
        end else begin
            drop_cnt_d = drop_sum[31:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// -----------------------------------------------------------------------------
// tb_rvfi_commit_serializer
// Directed scenarios for the dual-commit serializer (Depth 8). Expected
// records are queued when stimulus is issued; a monitor pops and compares
// on every accepted head record. Point checks cover reset state, latency,
// overflow, clear and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_rvfi_commit_serializer;

    typedef struct packed {
        logic        valid;
        logic [31:0] insn;
    } rec_t;

    typedef struct {
        logic [31:0] tag;
        logic [63:0] order;
    } exp_t;

    localparam config_pkg::cva6_cfg_t CFG = '{NrCommitPorts: 32'd2};
    localparam int NP    = 2;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              clear_i = 1'b0;
    logic              trace_ready_i = 1'b0;
    rec_t [NP-1:0]     rvfi_i;
    rec_t              trace_o;
    logic [63:0]       trace_order_o;
    logic              trace_valid_o;
    logic              overflow_o;
`ifdef RVFI_SERIALIZER_DROP_CNT_EN
    logic [31:0]       drop_cnt_o;
`endif

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    rvfi_commit_serializer #(
        .CVA6Cfg      (CFG),
        .rvfi_instr_t (rec_t),
        .Depth        (DEPTH)
    ) dut (
`ifdef RVFI_SERIALIZER_DROP_CNT_EN
        .drop_cnt_o    (drop_cnt_o),
`endif
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .rvfi_i        (rvfi_i),
        .clear_i       (clear_i),
        .trace_o       (trace_o),
        .trace_order_o (trace_order_o),
        .trace_valid_o (trace_valid_o),
        .trace_ready_i (trace_ready_i),
        .overflow_o    (overflow_o)
    );

    // Monitor: every accepted head record must match the scoreboard front.
    always @(negedge clk) begin
        if (rst_ni && trace_valid_o && trace_ready_i) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_record: got tag %h order %0d, scoreboard empty",
                         trace_o.insn, trace_order_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (trace_o.insn !== e.tag || trace_order_o !== e.order) begin
                    miscompares++;
                    $display("FAIL record: got tag %h order %0d, want tag %h order %0d",
                             trace_o.insn, trace_order_o, e.tag, e.order);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [31:0] t0,
                         input logic v1, input logic [31:0] t1);
        rvfi_i[0] = '{valid: v0, insn: t0};
        rvfi_i[1] = '{valid: v1, insn: t1};
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic expect_rec(input logic [31:0] tag, input logic [63:0] order);
        exp_t e;
        e.tag   = tag;
        e.order = order;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst_ni        = 1'b0;
        clear_i       = 1'b0;
        trace_ready_i = 1'b0;
        idle();
        sb.delete();
        repeat (2) tick();
        rst_ni = 1'b1;
    endtask

    // Bounded wait for the scoreboard and DUT to empty.
    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (sb.size() == 0 && !trace_valid_o) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s_drain: %0d records outstanding, trace_valid_o=%0b after 30 cycles",
                     name, sb.size(), trace_valid_o);
        end
    endtask

    initial begin
        idle();
        repeat (2) tick();
        // Reset state (reset held since time 0)
        chk("rst_valid", trace_valid_o, 0);
        chk("rst_overflow", overflow_o, 0);
        chk("rst_order", trace_order_o, 0);
        rst_ni = 1'b1;
        tick();

        // Dual push, ready high: orders 0 then 1, one cycle after commit
        trace_ready_i = 1'b1;
        drive(1'b1, 32'hA0, 1'b1, 32'hA1);
        expect_rec(32'hA0, 64'd0);
        expect_rec(32'hA1, 64'd1);
        #3;
        chk("dual_no_bypass", trace_valid_o, 0);
        tick();
        idle();
        chk("dual_visible", trace_valid_o, 1);
        chk("dual_first_order", trace_order_o, 0);
        tick();
        chk("dual_second_order", trace_order_o, 1);
        wait_drain("dual");

        // Sparse ports: port 1 only, then port 0 only
        do_reset();
        trace_ready_i = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 32'hB1);
        expect_rec(32'hB1, 64'd0);
        tick();
        drive(1'b1, 32'hB0, 1'b0, 32'h0);
        expect_rec(32'hB0, 64'd1);
        tick();
        idle();
        wait_drain("sparse");

        // Overflow: 5 cycles x 2 records into 8 entries, ready low
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'hC0 + 32'(2*k), 1'b1, 32'hC1 + 32'(2*k));
            if (k < 4) begin
                expect_rec(32'hC0 + 32'(2*k), 64'(2*k));
                expect_rec(32'hC1 + 32'(2*k), 64'(2*k + 1));
            end
            tick();
            if (k == 3) chk("ovf_not_yet", overflow_o, 0);
        end
        idle();
        chk("ovf_set", overflow_o, 1);
`ifdef RVFI_SERIALIZER_DROP_CNT_EN
        chk("ovf_drop_cnt", drop_cnt_o, 2);
`endif
        chk("ovf_head_tag", trace_o.insn, 32'hC0);
        tick();
        tick();
        chk("ovf_hold_tag", trace_o.insn, 32'hC0);
        chk("ovf_hold_order", trace_order_o, 0);
        trace_ready_i = 1'b1;
        wait_drain("ovf");
        chk("ovf_sticky", overflow_o, 1);

        // Full buffer with simultaneous pop and one push: push dropped
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'hD0 + 32'(2*k), 1'b1, 32'hD1 + 32'(2*k));
            expect_rec(32'hD0 + 32'(2*k), 64'(2*k));
            expect_rec(32'hD1 + 32'(2*k), 64'(2*k + 1));
            tick();
        end
        idle();
        chk("full_no_ovf", overflow_o, 0);
        trace_ready_i = 1'b1;
        drive(1'b1, 32'hD8, 1'b0, 32'h0);
        tick();
        idle();
        chk("full_pop_ovf", overflow_o, 1);
`ifdef RVFI_SERIALIZER_DROP_CNT_EN
        chk("full_pop_drop_cnt", drop_cnt_o, 1);
`endif
        wait_drain("full_pop");

        // Clear: buffered entries discarded, overflow cleared, order advances
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'hE0 + 32'(2*k), 1'b1, 32'hE1 + 32'(2*k));
            tick();
        end
        drive(1'b1, 32'hE8, 1'b0, 32'h0);
        tick();
        idle();
        chk("clr_pre_ovf", overflow_o, 1);
        clear_i = 1'b1;
        drive(1'b1, 32'hE9, 1'b0, 32'h0);
        tick();
        clear_i = 1'b0;
        idle();
        sb.delete();
        chk("clr_valid", trace_valid_o, 0);
        chk("clr_ovf", overflow_o, 0);
`ifdef RVFI_SERIALIZER_DROP_CNT_EN
        chk("clr_drop_cnt", drop_cnt_o, 0);
`endif
        trace_ready_i = 1'b1;
        drive(1'b1, 32'hF0, 1'b0, 32'h0);
        expect_rec(32'hF0, 64'd10);
        tick();
        idle();
        wait_drain("clr");

        // Mid-stream asynchronous reset
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h60 + 32'(2*k), 1'b1, 32'h61 + 32'(2*k));
            tick();
        end
        idle();
        chk("mrst_pre_valid", trace_valid_o, 1);
        #2;
        rst_ni = 1'b0;
        sb.delete();
        #1;
        chk("mrst_valid", trace_valid_o, 0);
        chk("mrst_order", trace_order_o, 0);
        chk("mrst_tag", trace_o.insn, 0);
        tick();
        tick();
        rst_ni = 1'b1;
        trace_ready_i = 1'b1;
        drive(1'b1, 32'h70, 1'b0, 32'h0);
        expect_rec(32'h70, 64'd0);
        tick();
        idle();
        wait_drain("mrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
